// File: rtl/a23_out_pkg.sv
// a23_out_pkg: shared definitions for the a23 output-memory streamer.
//   state_t   : streamer FSM encoding (IDLE, STREAM, DONE)
//   WORD_W    : width of one output-memory word
//   frame_len : number of words in one streamed frame
// Optional feature macro: A23_OUT_CHECKSUM_EN appends an XOR checksum word
// to every frame, so the frame is one word longer.
package a23_out_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int unsigned frame_len(input int unsigned mem_size);
`ifdef A23_OUT_CHECKSUM_EN
        return mem_size + 1;
`else
        return mem_size;
`endif
    endfunction

endpackage

// File: rtl/a23_out_word_sel.sv
// a23_out_word_sel: combinational selection of one 32-bit word from a
// flattened memory bus (word i = i_mem[32*(i+1)-1:32*i]).
//   i_mem  : flattened memory, N_WORDS words
//   i_idx  : word index; an index of N_WORDS or more selects zero
//   o_word : selected word
module a23_out_word_sel
    import a23_out_pkg::*;
#(
    parameter int unsigned N_WORDS = 64,
    parameter int unsigned IDX_W   = $clog2(N_WORDS + 1)
) (
    input  logic [N_WORDS*WORD_W-1:0] i_mem,
    input  logic [IDX_W-1:0]          i_idx,
    output logic [WORD_W-1:0]         o_word
);

    always_comb begin
        o_word = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_word = i_mem[i*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/a23_out_streamer.sv
// a23_out_streamer: on a rising edge of `terminate`, snapshots the a23 output
// memory and drains it word by word (word 0 first) over valid/ready.
//   clk, rst          : clock; synchronous active-low reset
//   o                 : flattened output memory (OUT_MEM_SIZE x 32 bits)
//   terminate         : processor finished (level, held high)
//   m_valid/m_ready   : stream handshake
//   m_data/m_index    : current word and its index
//   m_last            : current word is the final word of the frame
//   busy              : frame captured and not yet fully drained
//   done              : frame drained; clears once terminate drops
// Optional feature macro: A23_OUT_CHECKSUM_EN appends the XOR of all words
// as an extra final word with index OUT_MEM_SIZE.
module a23_out_streamer
    import a23_out_pkg::*;
#(
    parameter int unsigned OUT_MEM_SIZE = 64,
    parameter int unsigned IDX_W        = $clog2(OUT_MEM_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0] o,
    input  logic                          terminate,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WORD_W-1:0]             m_data,
    output logic [IDX_W-1:0]              m_index,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned      FRAME_LEN = frame_len(OUT_MEM_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    state_t                          r_state;
    logic [IDX_W-1:0]                r_cnt;
    logic                            r_term_d;
    logic                            r_armed;
    logic                            r_valid;
    logic                            r_last;
    logic                            r_busy;
    logic                            r_done;
    logic [OUT_MEM_SIZE*WORD_W-1:0]  r_snap;

    logic                            w_start;
    logic                            w_accept;
    logic [IDX_W-1:0]                w_cnt_nxt;
    logic [WORD_W-1:0]               w_word;
    logic [WORD_W-1:0]               w_data_sel;

    // r_armed blocks a frame when terminate is already high as reset
    // releases: a low level must be seen after reset before an edge counts.
    assign w_start   = terminate && !r_term_d && r_armed;
    assign w_accept  = r_valid && m_ready;
    assign w_cnt_nxt = r_cnt + IDX_W'(1);

    a23_out_word_sel #(
        .N_WORDS (OUT_MEM_SIZE),
        .IDX_W   (IDX_W)
    ) u_word_sel (
        .i_mem  (r_snap),
        .i_idx  (r_cnt),
        .o_word (w_word)
    );

`ifdef A23_OUT_CHECKSUM_EN
    logic [WORD_W-1:0] r_csum;
    logic              w_is_csum;

    assign w_is_csum  = (r_cnt == IDX_W'(OUT_MEM_SIZE));
    assign w_data_sel = w_is_csum ? r_csum : w_word;

    // Running XOR of accepted data words; complete by the time the
    // checksum slot is reached because words are accepted strictly in order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (r_state == IDLE && w_start) begin
            r_csum <= '0;
        end else if (w_accept && !w_is_csum) begin
            r_csum <= r_csum ^ w_word;
        end
    end
`else
    assign w_data_sel = w_word;
`endif

    // Snapshot has no reset; it is only observed while r_valid is high.
    always_ff @(posedge clk) begin
        if (rst && r_state == IDLE && w_start) begin
            r_snap <= o;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_term_d <= 1'b0;
            r_armed  <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_term_d <= terminate;
            if (!terminate) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_busy  <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt  <= w_cnt_nxt;
                            r_last <= (w_cnt_nxt == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (!terminate) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_valid = r_valid;
    assign m_data  = r_valid ? w_data_sel : '0;
    assign m_index = r_cnt;
    assign m_last  = r_last;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_a23_out_streamer.sv
module tb_a23_out_streamer;

    localparam int unsigned N    = 64;
    localparam int unsigned IW   = 7;
`ifdef A23_OUT_CHECKSUM_EN
    localparam bit          CSUM = 1'b1;
`else
    localparam bit          CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [31:0]   d;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*32-1:0]  o;
    logic             terminate;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic [IW-1:0]    m_index;
    logic             m_last;
    logic             busy;
    logic             done;

    int unsigned      checks   = 0;
    int unsigned      failures = 0;
    exp_t             exp_q[$];
    logic [31:0]      mem [N];
    logic [15:0]      lfsr = 16'hACE1;

    logic             prev_stall = 1'b0;
    logic [31:0]      prev_d;
    logic [IW-1:0]    prev_i;
    logic             prev_l;
    logic             pend_done = 1'b0;

    a23_out_streamer #(
        .OUT_MEM_SIZE (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .o         (o),
        .terminate (terminate),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_o();
        for (int i = 0; i < int'(N); i++) o[i*32 +: 32] = mem[i];
    endtask

    task automatic push_frame();
        exp_t        e;
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < int'(N); i++) begin
            e.d    = mem[i];
            e.idx  = IW'(i);
            e.last = (i == int'(N) - 1) && !CSUM;
            exp_q.push_back(e);
            x = x ^ mem[i];
        end
        if (CSUM) begin
            e.d    = x;
            e.idx  = IW'(N);
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic raise_frame();
        set_o();
        push_frame();
        terminate = 1'b1;
    endtask

    task automatic drain(input bit bp, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!done && n < budget) begin
            m_ready = bp ? lfsr[0] : 1'b1;
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tick();
            n++;
        end
        m_ready = 1'b1;
        chk("drain_done_reached", done, 1);
        chk("drain_all_words", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on each transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_stall = 1'b0;
            pend_done  = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_after_last", done, 1);
                chk("valid_after_last", m_valid, 0);
                pend_done = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_d);
                chk("stall_index", m_index, prev_i);
                chk("stall_last", m_last, prev_l);
            end
            prev_stall = 1'b0;
            if (m_valid) begin
                if (m_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word actual_index=%0d actual_data=%0h required=none", m_index, m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e.d || m_index !== e.idx || m_last !== e.last) begin
                            failures++;
                            $display("FAIL word actual=%0h/%0d/%0b required=%0h/%0d/%0b",
                                     m_data, m_index, m_last, e.d, e.idx, e.last);
                        end
                        if (e.last) pend_done = 1'b1;
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = m_data;
                    prev_i     = m_index;
                    prev_l     = m_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int unsigned vcnt;
        rst       = 1'b0;
        terminate = 1'b0;
        m_ready   = 1'b1;
        for (int i = 0; i < int'(N); i++) mem[i] = 32'hA5000000 + 32'(i);
        set_o();

        // Reset state.
        tick(); tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_index", m_index, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);

        // terminate already high while leaving reset must not start a frame.
        terminate = 1'b1;
        tick();
        rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_valid || busy) vcnt++;
        end
        chk("no_frame_out_of_reset", vcnt, 0);
        terminate = 1'b0;
        tick(); tick();

        // Basic drain with latency check.
        raise_frame();
        chk("latency_pre", m_valid, 0);
        tick();
        chk("latency_valid", m_valid, 1);
        chk("latency_busy", busy, 1);
        chk("first_index", m_index, 0);
        drain(1'b0, 300);
        chk("done_busy_low", busy, 0);

        // Re-arm: held terminate produces no frame; one-cycle drop re-arms.
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_valid) vcnt++;
        end
        chk("hold_no_frame", vcnt, 0);
        chk("hold_done", done, 1);
        terminate = 1'b0;
        tick();
        chk("done_cleared", done, 0);

        // Backpressure frame with the same contents.
        raise_frame();
        tick();
        drain(1'b1, 800);

        // Snapshot isolation with words 1..64.
        terminate = 1'b0;
        tick();
        for (int i = 0; i < int'(N); i++) mem[i] = 32'(i + 1);
        raise_frame();
        tick();
        for (int i = 0; i < int'(N); i++) o[i*32 +: 32] = 32'hDEADBEEF;
        drain(1'b0, 300);

        // Reset mid-frame at index 10.
        terminate = 1'b0;
        tick();
        for (int i = 0; i < int'(N); i++) mem[i] = 32'hA5000000 + 32'(i);
        raise_frame();
        vcnt = 0;
        while (m_index != IW'(10) && vcnt < 100) begin
            tick();
            vcnt++;
        end
        chk("reached_index10", m_index, 10);
        rst = 1'b0;
        tick();
        exp_q.delete();
        chk("midrst_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst       = 1'b1;
        terminate = 1'b0;
        tick(); tick();
        raise_frame();
        tick();
        chk("restart_index", m_index, 0);
        drain(1'b0, 300);

        terminate = 1'b0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a23_out_streamer.md
Name: a23_out_streamer

Overview:
- Reader-side counterpart to the a23_gc_main output memory; consumes the flattened `o` bus and `terminate`.
- On the rising edge of `terminate`, snapshots the whole output memory and streams it word by word, word 0 first, over a valid/ready interface.
- Replaces the bench-only memory dump with a synthesizable drain path to a host, UART or garbled-output collector.

Parameters:
- OUT_MEM_SIZE, 64, number of 32-bit words in the output memory (≥1).
- IDX_W, $clog2(OUT_MEM_SIZE+1), width of the word index and counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- o  in  OUT_MEM_SIZE*32  flattened output memory; word i = o[32*(i+1)-1:32*i].
- terminate  in  1  processor finished; level, held high after completion.
- m_valid  out  1  m_data/m_index/m_last are valid.
- m_ready  in  1  sink accepts the word when m_valid && m_ready.
- m_data  out  32  current word.
- m_index  out  IDX_W  index of the current word.
- m_last  out  1  current word is the final word of the frame.
- busy  out  1  snapshot held, frame not yet fully drained.
- done  out  1  frame fully drained; cleared when `terminate` deasserts.

Behaviour:
- Reset (rst=0 at a clk edge) sets:
  - state = IDLE; all outputs 0; counter 0; terminate_d 0.
  - The snapshot register is not reset.
- Reset mid-frame: m_valid is 0 from the next edge and the frame is abandoned.
- States are IDLE, STREAM and DONE.
- IDLE:
  - Start condition: terminate && !terminate_d, where terminate_d is registered.
  - On start, latch `o` into the snapshot, set counter = 0 and go to STREAM.
  - m_valid rises on the edge after the start edge, so latency is 1 cycle.
  - If terminate is already high when leaving reset, it does not start a frame; a low-then-high edge is required.
- STREAM:
  - m_valid = 1; m_data = snapshot word[counter]; m_index = counter.
  - m_last = (counter == OUT_MEM_SIZE-1).
  - On m_valid && m_ready with !m_last: counter increments and the next word is presented on the following cycle. Zero-bubble back-to-back transfers are required when m_ready stays high.
  - While m_valid && !m_ready: m_data, m_index and m_last are held stable.
  - On an accepted m_last: go to DONE; m_valid = 0 next cycle.
- DONE:
  - done = 1, busy = 0.
  - When terminate = 0, go to IDLE (done clears next cycle).
  - A terminate rising edge while in STREAM or DONE is ignored; there is no re-capture until IDLE.
- `o` changes after capture do not affect the streamed data.
- Edge case OUT_MEM_SIZE = 1: the first word carries m_last = 1.
- A frame takes at least OUT_MEM_SIZE transfer cycles.

Optional Feature:
- Macro: A23_OUT_CHECKSUM_EN.
- When defined:
  - One extra word is appended after word OUT_MEM_SIZE-1, with m_index = OUT_MEM_SIZE.
  - Its data is the XOR of all snapshot words. It is accumulated as words are accepted, or computed from the snapshot; either is acceptable if the value is correct.
  - m_last moves to this checksum word.
  - The frame length is OUT_MEM_SIZE+1.
- When undefined: the frame is exactly OUT_MEM_SIZE words, with no extra logic.

Decomposition:
- Package a23_out_pkg contains:
  - the state encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2);
  - the localparam WORD_W = 32;
  - a function giving the frame length (OUT_MEM_SIZE, or OUT_MEM_SIZE+1 when A23_OUT_CHECKSUM_EN is defined).
- Sub-module a23_out_word_sel: a combinational word select from the flattened snapshot by index, reusable for the g/e init paths.
- The FSM, counter and checksum accumulator stay in the top-level module.

Test Plan:
- Basic drain:
  - Stimulus: o word i = 32'hA5000000+i; m_ready tied 1; raise terminate after 28 ns of reset.
  - Required: m_valid rises 1 cycle after the edge; 64 consecutive words 0xA5000000..0xA500003F; m_last only on index 63; done the following cycle.
- Backpressure:
  - Stimulus: m_ready toggles with a pseudo-random pattern.
  - Required: no word is dropped or duplicated; m_data/m_index are stable during every stall; the sequence is identical to the basic drain.
- Snapshot isolation:
  - Stimulus: overwrite o with 32'hDEADBEEF in all words on the cycle after capture.
  - Required: the streamed data is still the pre-capture values.
- Re-arm:
  - Stimulus: hold terminate high after done; then drop it for 1 cycle; load new o; raise terminate again.
  - Required: no frame while terminate is held high; exactly one new frame after the new edge; done cleared in between.
- Reset mid-frame:
  - Stimulus: drive rst = 0 while index = 10.
  - Required: next cycle m_valid = 0, busy = 0, done = 0; after release a new terminate edge restarts at index 0.
- Checksum (A23_OUT_CHECKSUM_EN defined):
  - Stimulus: o words = 1,2,...,64.
  - Required: 65 words; the 65th (index 64) = 32'h00000040, the XOR of 1..64; m_last only on the 65th.
